// File: rtl/iencoder_if.sv
// iencoder_if: handshake bundle for the instruction encoder.
// The input channel carries decoded instruction fields.
// The output channel carries encoded RV32I words and their error flags.
// slave is the encoder's view of the bundle; master is the producer/consumer view.
interface iencoder_if #(
  parameter int INST_TYPE_WIDTH = 4,
  parameter int FUNCT_WIDTH     = 5,
  parameter int REG_WIDTH       = 5,
  parameter int IMM_WIDTH       = 32,
  parameter int INST_WIDTH      = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [INST_TYPE_WIDTH-1:0] in_inst_type;
  logic [FUNCT_WIDTH-1:0]     in_funct;
  logic [REG_WIDTH-1:0]       in_rd;
  logic [REG_WIDTH-1:0]       in_rs1;
  logic [REG_WIDTH-1:0]       in_rs2;
  logic [IMM_WIDTH-1:0]       in_imm;
  logic                       out_valid;
  logic                       out_ready;
  logic [INST_WIDTH-1:0]      out_inst;
  logic                       out_err;

  modport slave (
    input  in_valid, in_inst_type, in_funct, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );

  modport master (
    output in_valid, in_inst_type, in_funct, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/iencoder.sv
// iencoder: packs decoded instruction fields into RV32I words.
// Encoded words pass through a small output FIFO, and the block keeps
// running counts of words encoded and words flagged as errors.
// Optional feature: define IENCODER_RANGE_CHECK_EN to flag immediates that
// do not fit their instruction format. Such words are still encoded from
// the truncated immediate bits.
module iencoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  iencoder_if.slave   bus,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [3:0] T_IMM = 4'd0, T_INT_IMM = 4'd1, T_INT_REG = 4'd2, T_BRANCH = 4'd3,
                         T_STORE = 4'd4, T_LOAD = 4'd5, T_JAL = 4'd6, T_AUIPC = 4'd7,
                         T_JALR = 4'd8, T_FENCE = 4'd9;
  localparam logic [4:0] F_ADD = 5'd0, F_SUB = 5'd1, F_AND = 5'd2, F_SLL = 5'd3, F_SRL = 5'd4,
                         F_SRA = 5'd5, F_EQ = 5'd6, F_NEQ = 5'd7, F_LT = 5'd8, F_GTE = 5'd9,
                         F_LTU = 5'd10, F_GTEU = 5'd11, F_BYTE = 5'd12, F_HWORD = 5'd13,
                         F_WORD = 5'd14, F_BYTEU = 5'd15, F_HWORDU = 5'd16;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_INT_IMM = 7'b0010011, OP_INT_REG = 7'b0110011,
                         OP_BRANCH = 7'b1100011, OP_STORE = 7'b0100011, OP_LOAD = 7'b0000011;
  localparam logic [31:0] NOP_WORD = 32'h00000013;
  localparam logic [31:0] FENCE_WORD = 32'h0FF0000F;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  assign imm = bus.in_imm;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  // ---- stage p0: combinational encode of the presented fields ----
  logic [31:0] word_p0;
  logic        ok_p0;
  logic        err_p0;
  logic        vld_p0;
  logic [2:0]  funct3;

  // Build the instruction word; anything unrecognised falls back to NOP.
  always_comb begin
    word_p0 = NOP_WORD;
    ok_p0   = 1'b0;
    funct3  = 3'd0;
    case (bus.in_inst_type)
      T_IMM:   begin word_p0 = {imm[31:12], rd, OP_LUI};   ok_p0 = 1'b1; end
      T_AUIPC: begin word_p0 = {imm[31:12], rd, OP_AUIPC}; ok_p0 = 1'b1; end
      T_JAL: begin
        word_p0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        ok_p0   = 1'b1;
      end
      T_JALR:  begin word_p0 = {imm[11:0], rs1, 3'd0, rd, OP_JALR}; ok_p0 = 1'b1; end
      T_INT_IMM: begin
        ok_p0 = 1'b1;
        case (bus.in_funct)
          F_ADD:   word_p0 = {imm[11:0], rs1, 3'd0, rd, OP_INT_IMM};
          F_AND:   word_p0 = {imm[11:0], rs1, 3'd7, rd, OP_INT_IMM};
          F_SLL:   word_p0 = {7'b0000000, imm[4:0], rs1, 3'd1, rd, OP_INT_IMM};
          F_SRL:   word_p0 = {7'b0000000, imm[4:0], rs1, 3'd5, rd, OP_INT_IMM};
          F_SRA:   word_p0 = {7'b0100000, imm[4:0], rs1, 3'd5, rd, OP_INT_IMM};
          default: ok_p0 = 1'b0;
        endcase
      end
      T_INT_REG: begin
        ok_p0 = 1'b1;
        case (bus.in_funct)
          F_ADD:   word_p0 = {7'b0000000, rs2, rs1, 3'd0, rd, OP_INT_REG};
          F_SUB:   word_p0 = {7'b0100000, rs2, rs1, 3'd0, rd, OP_INT_REG};
          F_AND:   word_p0 = {7'b0000000, rs2, rs1, 3'd7, rd, OP_INT_REG};
          default: ok_p0 = 1'b0;
        endcase
      end
      T_BRANCH: begin
        ok_p0 = 1'b1;
        case (bus.in_funct)
          F_EQ:    funct3 = 3'd0;
          F_NEQ:   funct3 = 3'd1;
          F_LT:    funct3 = 3'd4;
          F_GTE:   funct3 = 3'd5;
          F_LTU:   funct3 = 3'd6;
          F_GTEU:  funct3 = 3'd7;
          default: ok_p0 = 1'b0;
        endcase
        if (ok_p0) word_p0 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      end
      T_STORE: begin
        ok_p0 = 1'b1;
        case (bus.in_funct)
          F_BYTE:  funct3 = 3'd0;
          F_HWORD: funct3 = 3'd1;
          F_WORD:  funct3 = 3'd2;
          default: ok_p0 = 1'b0;
        endcase
        if (ok_p0) word_p0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      end
      T_LOAD: begin
        ok_p0 = 1'b1;
        case (bus.in_funct)
          F_BYTE:   funct3 = 3'd0;
          F_HWORD:  funct3 = 3'd1;
          F_WORD:   funct3 = 3'd2;
          F_BYTEU:  funct3 = 3'd4;
          F_HWORDU: funct3 = 3'd5;
          default:  ok_p0 = 1'b0;
        endcase
        if (ok_p0) word_p0 = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      end
      T_FENCE: begin word_p0 = FENCE_WORD; ok_p0 = 1'b1; end
      default: ;
    endcase
  end

`ifdef IENCODER_RANGE_CHECK_EN
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] upper;
    upper = 32'($signed(v) >>> (bits - 1));
    return (upper == '0) || (upper == '1);
  endfunction

  logic range_bad_p0;

  // Flag immediates whose significant bits would be lost by the format.
  always_comb begin
    range_bad_p0 = 1'b0;
    case (bus.in_inst_type)
      T_IMM, T_AUIPC:         range_bad_p0 = (imm[11:0] != 12'd0);
      T_JAL:                  range_bad_p0 = !fits_signed(imm, 21) || imm[0];
      T_BRANCH:               range_bad_p0 = !fits_signed(imm, 13) || imm[0];
      T_JALR, T_STORE, T_LOAD: range_bad_p0 = !fits_signed(imm, 12);
      T_INT_IMM: begin
        if (bus.in_funct == F_SLL || bus.in_funct == F_SRL || bus.in_funct == F_SRA)
          range_bad_p0 = (imm[11:5] != 7'd0);
        else
          range_bad_p0 = !fits_signed(imm, 12);
      end
      default: ;
    endcase
  end

  assign err_p0 = !ok_p0 || range_bad_p0;
`else
  assign err_p0 = !ok_p0;
`endif

  // ---- stage p1: output FIFO holding {err, word} ----
  logic [32:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             pop;
  logic [32:0]      head_p1;

  assign full          = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign bus.in_ready  = !full && !flush;
  assign vld_p0        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready && !flush;
  assign head_p1       = mem[rd_ptr];
  assign bus.out_valid = (count != '0);
  assign bus.out_inst  = bus.out_valid ? head_p1[31:0] : 32'd0;
  assign bus.out_err   = bus.out_valid ? head_p1[32] : 1'b0;

  // Storage write for accepted words; contents need no reset.
  always_ff @(posedge clk) begin
    if (vld_p0) mem[wr_ptr] <= {err_p0, word_p0};
  end

  // FIFO pointers and occupancy; flush empties without touching counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (vld_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({vld_p0, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Running totals: encoded words wrap, error words saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (vld_p0) begin
      enc_count <= enc_count + 16'd1;
      if (err_p0) err_count <= sat_inc8(err_count);
    end
  end
endmodule

// File: tb/tb_iencoder.sv
// tb_iencoder: directed vector table, multi-cycle corner sequences and a
// randomized phase, all checked against a field-packing reference model.
`timescale 1ns/1ps
module tb_iencoder;
  localparam int DEPTH = 4;
  localparam int T_IMM = 0, T_INT_IMM = 1, T_INT_REG = 2, T_BRANCH = 3, T_STORE = 4,
                 T_LOAD = 5, T_JAL = 6, T_AUIPC = 7, T_JALR = 8, T_FENCE = 9;
  localparam int F_ADD = 0, F_SUB = 1, F_AND = 2, F_SLL = 3, F_SRL = 4, F_SRA = 5,
                 F_EQ = 6, F_NEQ = 7, F_LT = 8, F_GTE = 9, F_LTU = 10, F_GTEU = 11,
                 F_BYTE = 12, F_HWORD = 13, F_WORD = 14, F_BYTEU = 15, F_HWORDU = 16;
`ifdef IENCODER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  iencoder_if bus();

  iencoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, wanted %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: pick an instruction shape from the type/funct rules, then place fields by arithmetic.
  function automatic void model_enc(input int t, input int f, input logic [31:0] rd, input logic [31:0] rs1,
                                    input logic [31:0] rs2, input logic [31:0] imm,
                                    output logic [31:0] w, output logic e);
    int shape;  // 0 unsupported, 1 U, 2 J, 3 I, 4 shift, 5 R, 6 B, 7 S, 8 fence
    logic [31:0] op, f3, f7;
    logic bad;
    int si;
    shape = 0; op = 0; f3 = 0; f7 = 0; bad = 1'b0; si = $signed(imm);
    case (t)
      T_IMM:   begin shape = 1; op = 'h37; end
      T_AUIPC: begin shape = 1; op = 'h17; end
      T_JAL:   begin shape = 2; op = 'h6F; end
      T_JALR:  begin shape = 3; op = 'h67; end
      T_INT_IMM: begin
        op = 'h13;
        if (f == F_ADD) begin shape = 3; f3 = 0; end
        else if (f == F_AND) begin shape = 3; f3 = 7; end
        else if (f == F_SLL) begin shape = 4; f3 = 1; end
        else if (f == F_SRL) begin shape = 4; f3 = 5; end
        else if (f == F_SRA) begin shape = 4; f3 = 5; f7 = 32; end
      end
      T_INT_REG: begin
        op = 'h33;
        if (f == F_ADD) shape = 5;
        else if (f == F_SUB) begin shape = 5; f7 = 32; end
        else if (f == F_AND) begin shape = 5; f3 = 7; end
      end
      T_BRANCH: begin
        op = 'h63; shape = 6;
        if (f == F_EQ) f3 = 0; else if (f == F_NEQ) f3 = 1; else if (f == F_LT) f3 = 4;
        else if (f == F_GTE) f3 = 5; else if (f == F_LTU) f3 = 6; else if (f == F_GTEU) f3 = 7;
        else shape = 0;
      end
      T_STORE: begin
        op = 'h23; shape = 7;
        if (f == F_BYTE) f3 = 0; else if (f == F_HWORD) f3 = 1; else if (f == F_WORD) f3 = 2;
        else shape = 0;
      end
      T_LOAD: begin
        op = 'h03; shape = 3;
        if (f == F_BYTE) f3 = 0; else if (f == F_HWORD) f3 = 1; else if (f == F_WORD) f3 = 2;
        else if (f == F_BYTEU) f3 = 4; else if (f == F_HWORDU) f3 = 5;
        else shape = 0;
      end
      T_FENCE: shape = 8;
      default: shape = 0;
    endcase
    case (shape)
      1: begin w = (imm & 32'hFFFFF000) | (rd << 7) | op; bad = (imm % 4096) != 0; end
      2: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
          | (((imm >> 12) & 255) << 12) | (rd << 7) | op;
        bad = (si < -(1 << 20)) || (si >= (1 << 20)) || (imm % 2 != 0);
      end
      3: begin
        w = ((imm & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        bad = (si < -2048) || (si > 2047);
      end
      4: begin
        w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        bad = ((imm / 32) % 128) != 0;
      end
      5: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      6: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
          | (f3 << 12) | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | op;
        bad = (si < -4096) || (si > 4095) || (imm % 2 != 0);
      end
      7: begin
        w = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 31) << 7) | op;
        bad = (si < -2048) || (si > 2047);
      end
      8: w = 32'h0FF0000F;
      default: w = 32'h00000013;
    endcase
    e = (shape == 0) ? 1'b1 : (RC & bad);
  endfunction

  // Scoreboard: ordered queue of {err, word} plus counter models, all updated at negedge.
  logic [32:0] q[$];
  logic [15:0] m_enc = '0;
  logic [7:0]  m_err = '0;
  logic [31:0] mw;
  logic        me;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_enc = '0;
      m_err = '0;
    end
    check("mon_enc_count", 32'(enc_count), 32'(m_enc));
    check("mon_err_count", 32'(err_count), 32'(m_err));
    check("mon_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    check("mon_in_ready", 32'(bus.in_ready), 32'((q.size() < DEPTH) && !flush));
    if (q.size() != 0) begin
      check("mon_head_word", bus.out_inst, q[0][31:0]);
      check("mon_head_err", 32'(bus.out_err), 32'(q[0][32]));
    end else begin
      check("mon_idle_inst", bus.out_inst, 32'd0);
      check("mon_idle_err", 32'(bus.out_err), 32'd0);
    end
    if (rst) begin
      if (flush) q.delete();
      else begin
        if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
        if (bus.in_valid && bus.in_ready) begin
          model_enc(int'(bus.in_inst_type), int'(bus.in_funct), 32'(bus.in_rd), 32'(bus.in_rs1),
                    32'(bus.in_rs2), bus.in_imm, mw, me);
          q.push_back({me, mw});
          m_enc = m_enc + 16'd1;
          if (me && m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end
    end
  end

  typedef struct {
    int t; int f;
    logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic [31:0] imm; logic [31:0] w; logic e;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  task automatic drive(input int t, input int f, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_inst_type = 4'(t);
    bus.in_funct     = 5'(f);
    bus.in_rd        = rd;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_imm       = imm;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_err;
    int acc;
    tbl[0]  = '{T_INT_IMM, F_ADD,    5'd1,  5'd2, 5'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0};
    tbl[1]  = '{T_INT_REG, F_SUB,    5'd3,  5'd1, 5'd2, 32'h0,        32'h402081B3, 1'b0};
    tbl[2]  = '{T_BRANCH,  F_EQ,     5'd9,  5'd1, 5'd2, 32'h8,        32'h00208463, 1'b0};
    tbl[3]  = '{T_JAL,     F_ADD,    5'd1,  5'd0, 5'd0, 32'h3,        32'h002000EF, RC};
    tbl[4]  = '{T_INT_REG, F_SLL,    5'd1,  5'd2, 5'd3, 32'h0,        32'h00000013, 1'b1};
    tbl[5]  = '{T_FENCE,   F_SUB,    5'd7,  5'd8, 5'd9, 32'h12345678, 32'h0FF0000F, 1'b0};
    tbl[6]  = '{T_IMM,     F_ADD,    5'd5,  5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0};
    tbl[7]  = '{T_INT_IMM, F_SRA,    5'd2,  5'd3, 5'd0, 32'h7,        32'h4071D113, 1'b0};
    tbl[8]  = '{T_STORE,   F_WORD,   5'd0,  5'd2, 5'd3, 32'hFFFFFFFC, 32'hFE312E23, 1'b0};
    tbl[9]  = '{T_LOAD,    F_HWORDU, 5'd4,  5'd5, 5'd0, 32'h10,       32'h0102D203, 1'b0};
    tbl[10] = '{T_JALR,    F_ADD,    5'd1,  5'd6, 5'd0, 32'h7FF,      32'h7FF300E7, 1'b0};
    tbl[11] = '{T_AUIPC,   F_ADD,    5'd10, 5'd0, 5'd0, 32'h1000,     32'h00001517, 1'b0};
    tbl[12] = '{15,        F_ADD,    5'd1,  5'd1, 5'd1, 32'h0,        32'h00000013, 1'b1};
    tbl[13] = '{T_INT_IMM, F_SUB,    5'd1,  5'd1, 5'd0, 32'h0,        32'h00000013, 1'b1};
    tbl[14] = '{T_BRANCH,  F_GTEU,   5'd0,  5'd1, 5'd2, 32'hFFFFFFFE, 32'hFE20FFE3, 1'b0};
    tbl[15] = '{T_IMM,     F_ADD,    5'd0,  5'd0, 5'd0, 32'h1,        32'h00000037, RC};
    tbl[16] = '{T_INT_IMM, F_SLL,    5'd1,  5'd1, 5'd0, 32'h20,       32'h00009093, RC};
    tbl[17] = '{T_INT_REG, F_AND,    5'd3,  5'd4, 5'd5, 32'h0,        32'h005271B3, 1'b0};

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 5'd0, 5'd0, 5'd0, 32'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Table vectors: one push, word visible the next cycle, then popped.
    n_err = 0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].t, tbl[i].f, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
      bus.in_valid = 1'b1;
      check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      check($sformatf("vec%0d_not_yet", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_word", i), bus.out_inst, tbl[i].w);
      check($sformatf("vec%0d_err", i), 32'(bus.out_err), 32'(tbl[i].e));
      if (tbl[i].e) n_err++;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_popped", i), 32'(bus.out_valid), 32'd0);
    end
    check("tbl_enc_count", 32'(enc_count), 32'(NV));
    check("tbl_err_count", 32'(err_count), 32'(n_err));

    // Fill to full, hold a fifth word, then drain in order.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(T_INT_IMM, F_ADD, 5'(k + 1), 5'd0, 5'd0, 32'(k));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    check("full_head", bus.out_inst, 32'h00000093);
    drive(T_INT_IMM, F_ADD, 5'd5, 5'd0, 5'd0, 32'd4);
    @(posedge clk); #1;
    check("full_no_passthru", 32'(enc_count), 32'(NV + 4));
    bus.out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 10 && acc == 0; c++) begin
      if (bus.in_ready) acc = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("fifth_accepted", 32'(acc), 32'd1);
    drain("full_drained");
    check("full_enc_count", 32'(enc_count), 32'(NV + 5));

    // Asynchronous reset with two entries buffered.
    bus.out_ready = 1'b0;
    drive(T_INT_REG, F_SLL, 5'd1, 5'd1, 5'd1, 32'd0);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_inst", bus.out_inst, 32'd0);
    check("midrst_enc_count", 32'(enc_count), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Flush with a word offered: not accepted, FIFO empty afterwards.
    drive(T_INT_IMM, F_ADD, 5'd1, 5'd0, 5'd0, 32'd1);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_empty", 32'(bus.out_valid), 32'd0);
    check("flush_enc_count", 32'(enc_count), 32'd2);

    // 300 unsupported words streamed through: err_count pins at 255.
    drive(T_INT_REG, F_SLL, 5'd2, 5'd3, 5'd4, 32'd0);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("sat_err_count", 32'(err_count), 32'd255);
    check("sat_enc_count", 32'(enc_count), 32'd302);
    drain("sat_drained");

    // Randomized traffic against the scoreboard.
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] imm;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = $urandom & 32'hFFFFF000;
        default: imm = 32'($urandom_range(0, 31));
      endcase
      drive(int'($urandom_range(0, 11)),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 16)),
            5'($urandom), 5'($urandom), 5'($urandom), imm);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    bus.in_valid = 1'b0;
    drain("rand_drained");
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
